// File: rtl/execon_gen_pkg.sv
// Shared constants and width helpers for the execution controller.
// State codes are plain constants so they stay readable in legacy waveform viewers.
package execon_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_IMM  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  // Bits needed to hold a count in the range 0..n.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // Bits needed to index n items (0..n-1), never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/execon_gen_if.sv
// Prefetch / execute pipeline handshake between the controller (master)
// and the prefetch queue plus ALU write-back side (slave).
interface execon_gen_if #(
  parameter int MAX_IMM = 2
);
  import execon_gen_pkg::*;

  localparam int IMM_W = cnt_w(MAX_IMM);
  localparam int IDX_W = idx_w(MAX_IMM);

  logic             insrdy;
  logic             immld;
  logic [IMM_W-1:0] imm_len;
  logic             memrw;
  logic             datwe;
  logic             precomp;
  logic             exe;
  logic             insexe;
  logic             romold;
  logic             immwri;
  logic [IDX_W-1:0] imm_idx;
  logic             dstdgate;

  modport master (
    input  insrdy, immld, imm_len, memrw, datwe, precomp,
    output exe, insexe, romold, immwri, imm_idx, dstdgate
  );

  modport slave (
    output insrdy, immld, imm_len, memrw, datwe, precomp,
    input  exe, insexe, romold, immwri, imm_idx, dstdgate
  );

endinterface

// File: rtl/execon_gen_cwait.sv
// Post-compute store wait: holds off the next instruction for COMP_WAIT
// cycles after a precomputed store and flags the final wait cycle.
module execon_cwait
  import execon_gen_pkg::*;
#(
  parameter int COMP_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic last
);

  localparam int             CW_W    = cnt_w(COMP_WAIT);
  localparam logic [CW_W-1:0] CW_INIT = CW_W'(COMP_WAIT);
  localparam logic [CW_W-1:0] CW_ONE  = CW_W'(1'b1);
  localparam logic [CW_W-1:0] CW_ZERO = {CW_W{1'b0}};

  logic [CW_W-1:0] cnt_r;

  // Wait down-counter, reloaded by every precomputed store.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CW_ZERO;
    end else if (load) begin
      cnt_r <= CW_INIT;
    end else if (cnt_r != CW_ZERO) begin
      cnt_r <= cnt_r - CW_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != CW_ZERO);
  assign last = (cnt_r == CW_ONE);

endmodule

// File: rtl/execon_gen.sv
// Execution controller: gates instruction execution, sequences immediate
// extension words, and enforces the single-step instruction budget.
module execon_gen
  import execon_gen_pkg::*;
#(
  parameter int NWAIT     = 3,
  parameter int MAX_IMM   = 2,
  parameter int STEP_W    = 8,
  parameter int COMP_WAIT = 1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              go,
  input  logic              single_step,
  input  logic              single_go,
  input  logic [STEP_W-1:0] step_count,
  input  logic [NWAIT-1:0]  wait_req,
  output logic              stop,
  output logic              idle,
  output logic [STEP_W-1:0] step_left,
  execon_gen_if.master      bus
);

  localparam int               IMM_W    = cnt_w(MAX_IMM);
  localparam int               IDX_W    = idx_w(MAX_IMM);
  localparam logic [IMM_W-1:0] LEN_MAX  = IMM_W'(MAX_IMM);
  localparam logic [IMM_W-1:0] LEN_ONE  = IMM_W'(1'b1);
  localparam logic [IMM_W-1:0] LEN_ZERO = {IMM_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1'b1);
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

  logic [1:0]        state_r, state_s, done_state_s;
  logic [IMM_W-1:0]  imm_cnt_r, imm_cnt_s, len_clamp_s;
  logic [IDX_W-1:0]  imm_idx_r, imm_idx_s;
  logic [STEP_W-1:0] step_r, step_s, done_step_s;
  logic              insexe_r, stop_r, idle_r;
  logic              stall_s, exe_s, immwri_s, cw_load_s, cw_busy_s, cw_last_s;

  execon_cwait #(
    .COMP_WAIT (COMP_WAIT)
  ) u_cwait (
    .clk   (sys_clk),
    .reset (reset),
    .load  (cw_load_s),
    .busy  (cw_busy_s),
    .last  (cw_last_s)
  );

  // Same-cycle strobes; forced low while reset is asserted so an aborted
  // immediate sequence never produces a stray write.
  always_comb begin
    stall_s   = (|wait_req) | cw_busy_s;
    exe_s     = ~reset & (state_r == ST_EXEC) & go & bus.insrdy & ~stall_s;
    immwri_s  = ~reset & (state_r == ST_IMM) & bus.insrdy;
    cw_load_s = exe_s & bus.memrw & bus.datwe & bus.precomp;
    if (bus.immld) begin
      len_clamp_s = (bus.imm_len > LEN_MAX) ? LEN_MAX : bus.imm_len;
    end else begin
      len_clamp_s = LEN_ZERO;
    end
  end

  // Where an instruction completing this cycle sends us, and the new budget.
  always_comb begin
    if (single_step) begin
      done_step_s  = (step_r == STEP_ZERO) ? STEP_ZERO : step_r - STEP_ONE;
      done_state_s = (step_r <= STEP_ONE) ? ST_STOP : ST_EXEC;
    end else begin
      done_step_s  = step_r;
      done_state_s = go ? ST_EXEC : ST_IDLE;
    end
  end

  // Main controller next-state.
  always_comb begin
    state_s   = state_r;
    imm_cnt_s = imm_cnt_r;
    imm_idx_s = imm_idx_r;
    step_s    = step_r;
    case (state_r)
      ST_IDLE: begin
        state_s = go ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        if (!go) begin
          state_s = ST_IDLE;
        end else if (exe_s && (len_clamp_s != LEN_ZERO)) begin
          state_s   = ST_IMM;
          imm_cnt_s = len_clamp_s;
          imm_idx_s = IDX_ZERO;
        end else if (exe_s) begin
          state_s = done_state_s;
          step_s  = done_step_s;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_IMM: begin
        // Atomic sequence: go and wait_req are deliberately ignored here.
        if (bus.insrdy && (imm_cnt_r == LEN_ONE)) begin
          state_s   = done_state_s;
          step_s    = done_step_s;
          imm_cnt_s = LEN_ZERO;
          imm_idx_s = IDX_ZERO;
        end else if (bus.insrdy) begin
          imm_cnt_s = imm_cnt_r - LEN_ONE;
          imm_idx_s = imm_idx_r + IDX_ONE;
        end else begin
          state_s = ST_IMM;
        end
      end
      ST_STOP: begin
        if (!go) begin
          state_s = ST_IDLE;
        end else if (single_go) begin
          state_s = ST_EXEC;
          step_s  = (step_count == STEP_ZERO) ? STEP_ONE : step_count;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State registers; the flag outputs follow the next state so they are
  // zero in the first cycle after reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      imm_cnt_r <= LEN_ZERO;
      imm_idx_r <= IDX_ZERO;
      step_r    <= STEP_ZERO;
      insexe_r  <= 1'b0;
      stop_r    <= 1'b0;
      idle_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      imm_cnt_r <= imm_cnt_s;
      imm_idx_r <= imm_idx_s;
      step_r    <= step_s;
      insexe_r  <= exe_s;
      stop_r    <= (state_s == ST_STOP);
      idle_r    <= (state_s == ST_IDLE);
    end
  end

  assign bus.exe      = exe_s;
  assign bus.immwri   = immwri_s;
  assign bus.romold   = exe_s | immwri_s;
  assign bus.dstdgate = ~reset & ((exe_s & bus.memrw & bus.datwe & ~bus.precomp) | cw_last_s);
  assign bus.insexe   = insexe_r;
  assign bus.imm_idx  = imm_idx_r;
  assign stop         = stop_r;
  assign idle         = idle_r;
  assign step_left    = step_r;

endmodule
